// File: rtl/mod_reg4_4to1.sv
`default_nettype none
// ============================================================================
// Module   : mod_reg4_4to1
// Brief    : Parallel-to-serial byte register. Captures an N-byte word in one
//            cycle and emits it one byte per accepted read request.
//            Optional macro MOD_REG4_4TO1_MSB_FIRST_EN reverses the pop order.
// Revision : 1.0 - initial release
// ============================================================================
module mod_reg4_4to1 #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [N-1:0][7:0]   i,
    input  logic                rd_en,
    output logic [7:0]          o,
    output logic                o_valid,
    output logic                reg_empty,
    output logic [CW-1:0]       byte_idx
);

    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic [0:0] {
        S_LOADED = 1'b0,
        S_EMPTY  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N-1:0][7:0]   r_aux;
    logic [N-1:0][7:0]   w_aux_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [7:0]          r_o;
    logic [7:0]          w_o_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic [CW-1:0]       w_sel;

    // byte_idx is the pop count; the MSB-first build maps it to N-1-k,
    // which for a power-of-two N is simply the bitwise inverse.
`ifdef MOD_REG4_4TO1_MSB_FIRST_EN
    assign w_sel = ~r_cnt;
`else
    assign w_sel = r_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_aux   <= '0;
            r_cnt   <= '0;
            r_o     <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_aux   <= w_aux_nxt;
            r_cnt   <= w_cnt_nxt;
            r_o     <= w_o_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_aux_nxt   = r_aux;
        w_cnt_nxt   = r_cnt;
        w_o_nxt     = r_o;
        w_valid_nxt = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (wr_en) begin
                    w_aux_nxt   = i;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_LOADED;
                end
            end
            S_LOADED: begin
                if (rd_en) begin
                    w_o_nxt     = r_aux[w_sel];
                    w_valid_nxt = 1'b1;
                    if (r_cnt == C_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_EMPTY;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    assign o         = r_o;
    assign o_valid   = r_valid;
    assign reg_empty = (r_state == S_EMPTY);
    assign byte_idx  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mod_reg4_4to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_reg4_4to1
// Brief    : Self-checking bench for mod_reg4_4to1 against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_reg4_4to1;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int VW = 8 + 1 + 1 + CW;

    logic               clk = 1'b0;
    logic               reset;
    logic               wr_en;
    logic [N-1:0][7:0]  i;
    logic               rd_en;
    logic [7:0]         o;
    logic               o_valid;
    logic               reg_empty;
    logic [CW-1:0]      byte_idx;

    int errors = 0;
    int checks = 0;

    // Reference model: pending bytes in pop order, plus last output.
    logic [7:0] m_q[$];
    logic [7:0] m_o;
    logic       m_valid;

    mod_reg4_4to1 #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .i         (i),
        .rd_en     (rd_en),
        .o         (o),
        .o_valid   (o_valid),
        .reg_empty (reg_empty),
        .byte_idx  (byte_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] exp_vec();
        int idx;
        idx = (N - m_q.size()) % N;
        return {m_o, m_valid, (m_q.size() == 0), idx[CW-1:0]};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {o, o_valid, reg_empty, byte_idx};
    endfunction

    // Drive one cycle of inputs, advance the model over the edge, settle.
    task automatic step(input logic rst, input logic wr, input logic [N*8-1:0] data,
                        input logic rd);
        logic [N-1:0][7:0] d;
        d = data;
        reset = rst; wr_en = wr; i = d; rd_en = rd;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_o = 8'h00;
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_q.size() == 0) begin
                if (wr) begin
                    for (int k = 0; k < N; k++) begin
`ifdef MOD_REG4_4TO1_MSB_FIRST_EN
                        m_q.push_back(d[N-1-k]);
`else
                        m_q.push_back(d[k]);
`endif
                    end
                end
            end else if (rd) begin
                m_o = m_q.pop_front();
                m_valid = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
        checks++;
        if (act_vec() !== {8'h00, 1'b0, 1'b1, {CW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", act_vec(), {8'h00, 1'b0, 1'b1, {CW{1'b0}}});
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (o_valid !== 1'b0 || reg_empty !== 1'b1) begin
                errors++;
                $display("FAIL reset_rd_ignored c%0d: got valid=%b empty=%b want valid=0 empty=1",
                         c, o_valid, reg_empty);
            end
        end
    endtask

    task automatic test_full_drain();
        logic [7:0] last_exp;
`ifdef MOD_REG4_4TO1_MSB_FIRST_EN
        last_exp = 8'h11;
`else
        last_exp = 8'h44;
`endif
        step(1'b0, 1'b1, 32'h44332211, 1'b0);
        checks++;
        if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL drain_load: got %h want %h", act_vec(), exp_vec());
        end
        for (int c = 0; c < N; c++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drain_pop%0d: got %h want %h", c, act_vec(), exp_vec());
            end
        end
        step(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (o !== last_exp || o_valid !== 1'b0 || reg_empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_hold: got o=%h v=%b e=%b want o=%h v=0 e=1",
                     o, o_valid, reg_empty, last_exp);
        end
    endtask

    task automatic test_stall();
        step(1'b0, 1'b1, 32'h44332211, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            checks++;
            if (act_vec() !== exp_vec() || byte_idx !== CW'(2)) begin
                errors++;
                $display("FAIL stall_gap%0d: got %h want %h", c, act_vec(), exp_vec());
            end
        end
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall_resume%0d: got %h want %h", c, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_write_ignored();
        step(1'b0, 1'b1, 32'h44332211, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 32'hAABBCCDD, 1'b0);
        checks++;
        if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL wr_ignored_idle: got %h want %h", act_vec(), exp_vec());
        end
        for (int c = 0; c < N - 1; c++) begin
            step(1'b0, 1'b1, 32'hAABBCCDD, 1'b1);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wr_ignored_pop%0d: got %h want %h", c, act_vec(), exp_vec());
            end
        end
        step(1'b0, 1'b1, 32'hAABBCCDD, 1'b1);
        checks++;
        if (act_vec() !== exp_vec() || reg_empty !== 1'b0) begin
            errors++;
            $display("FAIL wr_after_empty: got %h want %h", act_vec(), exp_vec());
        end
        for (int c = 0; c < N; c++) step(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL wr_second_drain: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 32'h44332211, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 32'h55555555, 1'b1);
        checks++;
        if (act_vec() !== {8'h00, 1'b0, 1'b1, {CW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_mid: got %h want %h", act_vec(), {8'h00, 1'b0, 1'b1, {CW{1'b0}}});
        end
        step(1'b0, 1'b1, 32'h04030201, 1'b0);
        for (int c = 0; c < N; c++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_drain%0d: got %h want %h", c, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic rst, wr, rd;
        logic [N*8-1:0] data;
        for (int c = 0; c < 400; c++) begin
            rst  = ($urandom_range(0, 59) == 0);
            wr   = ($urandom_range(0, 2) != 0);
            rd   = ($urandom_range(0, 3) != 0);
            data = $urandom;
            step(rst, wr, data, rd);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random c%0d: got %h want %h", c, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; i = '0; rd_en = 1'b0;
        m_o = 8'h00; m_valid = 1'b0;
        test_reset();
        test_full_drain();
        test_stall();
        test_write_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
